// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the ID-stage decoder.
package mdu_pkg;

  // Op encodings shared with the ID-stage decoder
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Result of one long operation; wr=0 means leave HI/LO untouched
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // True for the ops that occupy the unit for several cycles
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit HI/LO result for MULT/MULTU/DIV/DIVU.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output mdu_res_t    o_res
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic               w_b_zero;
  logic               w_ovf;

  assign w_sprod  = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod  = {32'd0, i_a} * {32'd0, i_b};
  assign w_sa     = $signed(i_a);
  assign w_sb     = $signed(i_b);
  assign w_b_zero = (i_b == 32'd0);
  // Most-negative / -1 overflows a signed divider; pinned to MIPS result
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Select the product or quotient/remainder; divide by zero leaves wr=0
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_MULT: begin
        o_res.wr = 1'b1;
        o_res.hi = w_sprod[63:32];
        o_res.lo = w_sprod[31:0];
      end
      OP_MULTU: begin
        o_res.wr = 1'b1;
        o_res.hi = w_uprod[63:32];
        o_res.lo = w_uprod[31:0];
      end
      OP_DIV: begin
        if (!w_b_zero) begin
          o_res.wr = 1'b1;
          if (w_ovf) begin
            o_res.hi = 32'd0;
            o_res.lo = 32'h8000_0000;
          end else begin
            o_res.hi = w_sa % w_sb;
            o_res.lo = w_sa / w_sb;
          end
        end
      end
      OP_DIVU: begin
        if (!w_b_zero) begin
          o_res.wr = 1'b1;
          o_res.hi = i_a % i_b;
          o_res.lo = i_a / i_b;
        end
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is computed at
// acceptance and committed after a fixed busy window.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall_Req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mdu_res_t         r_res;
  mdu_res_t         w_calc;
  logic             w_is_md;
  logic             w_accept;
  logic             w_launch;
  logic             w_done;

  mdu_calc u_calc (
    .i_op  (Op),
    .i_a   (A),
    .i_b   (B),
    .o_res (w_calc)
  );

  assign w_is_md   = is_muldiv(Op);
  assign w_accept  = Start & (r_state == ST_IDLE);
  assign w_launch  = w_accept & w_is_md;
  assign Stall_Req = (Start & w_is_md) | Busy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave RUN when the counter is on its last cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy   = (r_state == ST_RUN);
    w_done = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
  end

  // Busy-window counter, loaded at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_launch) begin
      r_cnt <= ((Op == OP_DIV) || (Op == OP_DIVU)) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Latch the result at acceptance so later A/B changes are irrelevant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_res <= '0;
    else if (w_launch) r_res <= w_calc;
  end

  // HI/LO: commit long-op result at end of RUN, or immediate MTHI/MTLO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else if (w_done) begin
      if (r_res.wr) begin
        HI <= r_res.hi;
        LO <= r_res.lo;
      end
    end else if (w_accept && (Op == OP_MTHI)) begin
      HI <= A;
    end else if (w_accept && (Op == OP_MTLO)) begin
      LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Stall_Req;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Stall_Req (Stall_Req),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply one op to the architectural HI/LO model
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    longint sa, sb, q, r;
    logic [63:0] p;
    cyc = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
      3'd3: begin
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        cyc = DC;
      end
      3'd4: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        cyc = DC;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, scramble A/B during the busy window, return busy cycles seen
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic stall);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    #1 stall = Stall_Req;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0; A = $urandom; B = $urandom;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      A = $urandom; B = $urandom;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    total++;
    if (Busy !== 1'b0 || Stall_Req !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h want 0 0 0 0", Busy, Stall_Req, HI, LO);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int cyc, ecyc; logic st;
    logic [2:0]  ops [4] = '{3'd1, 3'd2, 3'd3, 3'd6};
    logic [31:0] as  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0};
    logic [31:0] bs  [4] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0};
    logic [31:0] eh  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] el  [4] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'h0};
    for (int i = 0; i < 4; i++) begin
      model_op(ops[i], as[i], bs[i], ecyc);
      do_op(ops[i], as[i], bs[i], cyc, st);
      total++;
      if (cyc != ecyc || HI !== eh[i] || LO !== el[i] || HI !== m_hi || LO !== m_lo) begin
        bad++;
        $display("FAIL directed[%0d]: cyc=%0d hi=%h lo=%h want cyc=%0d hi=%h lo=%h",
                 i, cyc, HI, LO, ecyc, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div_special;
    int cyc, ecyc; logic st;
    // preload HI/LO, then DIVU by zero must keep them
    model_op(3'd5, 32'h11, 0, ecyc); do_op(3'd5, 32'h11, 32'd0, cyc, st);
    model_op(3'd6, 32'h22, 0, ecyc); do_op(3'd6, 32'h22, 32'd0, cyc, st);
    total++;
    if (HI !== 32'h11 || LO !== 32'h22 || cyc != 0) begin
      bad++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h cyc=%0d want 11 22 0", HI, LO, cyc);
    end
    model_op(3'd4, 32'h1234_5678, 32'd0, ecyc);
    do_op(3'd4, 32'h1234_5678, 32'd0, cyc, st);
    total++;
    if (cyc != DC || HI !== 32'h11 || LO !== 32'h22) begin
      bad++;
      $display("FAIL divu_zero: cyc=%0d hi=%h lo=%h want %0d 11 22", cyc, HI, LO, DC);
    end
    model_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, ecyc);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, st);
    total++;
    if (cyc != DC || HI !== 32'd0 || LO !== 32'h8000_0000 || LO !== m_lo) begin
      bad++;
      $display("FAIL div_ovf: cyc=%0d hi=%h lo=%h want %0d 0 80000000", cyc, HI, LO, DC);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc, ecyc; logic [31:0] ph, pl;
    model_op(3'd3, 32'd100, 32'd7, ecyc);
    @(negedge clk);
    Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 200) begin
      cyc++;
      ph = HI; pl = LO;
      if (cyc == 3) begin
        Start = 1'b1; Op = 3'd1; A = 32'd5; B = 32'd6;
        #1;
        total++;
        if (Stall_Req !== 1'b1) begin
          bad++;
          $display("FAIL stall_busy: stall=%b want 1", Stall_Req);
        end
      end
      @(negedge clk);
      Start = 1'b0; Op = 3'd0;
    end
    total++;
    if (cyc != DC || HI !== m_hi || LO !== m_lo) begin
      bad++;
      $display("FAIL busy_ignore: cyc=%0d hi=%h lo=%h want %0d %h %h", cyc, HI, LO, DC, m_hi, m_lo);
    end
    repeat (2) @(negedge clk);
    total++;
    if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      bad++;
      $display("FAIL busy_ignore_after: busy=%b hi=%h lo=%h want 0 %h %h", Busy, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc; logic seen;
    @(negedge clk);
    Start = 1'b1; Op = 3'd1; A = 32'd9; B = 32'd9;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0;
    @(negedge clk); // busy cycle 2
    rst_n = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0 0 0", Busy, HI, LO);
    end
    // Start during reset must be ignored
    Start = 1'b1; Op = 3'd5; A = 32'hDEAD;
    repeat (2) @(negedge clk);
    total++;
    if (HI !== 32'd0) begin
      bad++;
      $display("FAIL start_in_reset: hi=%h want 0", HI);
    end
    // release with MTLO already presented: first edge must accept it
    Op = 3'd6; A = 32'h1234;
    rst_n = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0;
    m_lo = 32'h1234;
    total++;
    if (LO !== 32'h1234 || HI !== 32'd0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo_after_reset: lo=%h hi=%h busy=%b want 1234 0 0", LO, HI, Busy);
    end
    seen = 1'b0;
    for (cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'h1234) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL no_late_write: hi=%h lo=%h busy=%b want 0 1234 0", HI, LO, Busy);
    end
  endtask

  task automatic test_random;
    int cyc, ecyc; logic st, est;
    logic [2:0] op; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      est = (op >= 3'd1 && op <= 3'd4);
      model_op(op, a, b, ecyc);
      do_op(op, a, b, cyc, st);
      total++;
      if (cyc != ecyc || st !== est || HI !== m_hi || LO !== m_lo) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: cyc=%0d stall=%b hi=%h lo=%h want %0d %b %h %h",
                 i, op, a, b, cyc, st, HI, LO, ecyc, est, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_special;
    test_start_while_busy;
    test_reset_mid_run;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  issue Op this cycle (EXE stage, valid instruction).
REQ-006 SHALL have port Op  input  3  operation code (see REQ-010).
REQ-007 SHALL have port A  input  32  forwarded rs value.
REQ-008 SHALL have port B  input  32  forwarded rt value.
REQ-009 SHALL have ports Busy, Stall_Req, HI, LO as outputs:
- Busy  output  1  operation in flight.
- Stall_Req  output  1  Start & Op is MULT/MULTU/DIV/DIVU, or Busy; drives the hazard unit.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register; the EXE stage muxes HI/LO into AO for mfhi/mflo.

Function
REQ-010 SHALL decode Op as follows:
- 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- 7 is reserved and treated as NONE.
REQ-011 SHALL accept an operation only when Start=1 and Busy=0; Start while Busy=1 SHALL be ignored with no state change.
REQ-012 SHALL have exactly two states, IDLE and RUN:
- IDLE->RUN on an accepted MULT/MULTU/DIV/DIVU.
- RUN->IDLE when the cycle counter reaches 1.
REQ-013 SHALL latch operands and the result at acceptance and load the counter with MULT_CYCLES or DIV_CYCLES; later A/B changes SHALL have no effect.
REQ-014 SHALL hold Busy=1 for exactly MULT_CYCLES (or DIV_CYCLES) cycles, starting on the edge after acceptance.
REQ-015 SHALL write HI/LO on the edge that ends RUN, so new values are visible in the first cycle with Busy=0.
REQ-016 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned 32x32->64, with HI=product[63:32] and LO=product[31:0].
REQ-017 SHALL compute DIV/DIVU as LO=quotient and HI=remainder, signed for DIV and unsigned for DIVU.
REQ-018 SHALL truncate the DIV quotient toward zero, with the remainder taking the sign of the dividend.
REQ-019 SHALL leave HI and LO unchanged on divide by zero (B=0), while still consuming DIV_CYCLES of Busy.
REQ-020 SHALL return LO=0x80000000 and HI=0 for DIV with A=0x80000000 and B=0xFFFFFFFF.
REQ-021 SHALL write A to HI (MTHI) or to LO (MTLO) on the accepting edge, with no Busy.
REQ-022 SHALL take no action for NONE or reserved Op.
REQ-023 SHALL drive HI/LO straight from registers, with no combinational path from A/B.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous), clear state to IDLE and clear counter, Busy, HI, LO and the latched result to 0.
REQ-025 SHALL abort any in-flight operation on reset mid-RUN, with no HI/LO write.
REQ-026 SHALL ignore Start while rst_n=0, and SHALL accept Start on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place the Op encodings and the default MULT_CYCLES/DIV_CYCLES constants in shared package mdu_pkg, which the ID-stage decoder also uses.
REQ-028 SHALL place the 64-bit result calculation (REQ-016 to REQ-020) in combinational sub-module mdu_calc; mult_div_unit owns the FSM, counter and HI/LO.

Verification
REQ-029 SHALL cover MULT: A=0xFFFFFFFE, B=3 -> Busy for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-030 SHALL cover MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE and LO=0x00000001 after 5 cycles.
REQ-031 SHALL cover DIV: A=-7 (0xFFFFFFF9), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-032 SHALL cover DIVU by zero, with HI/LO preloaded 0x11/0x22 -> Busy for 10 cycles, then HI=0x11 and LO=0x22.
REQ-033 SHALL cover Start of a MULT with A=5, B=6 on busy cycle 3 of a DIV -> the MULT is ignored, and only the DIV result is written.
REQ-034 SHALL cover rst_n pulsed low in busy cycle 2 of a MULT -> Busy=0 and HI=LO=0 immediately, with no later write; then MTLO with A=0x1234 -> LO=0x1234 after one edge.
